// File: rtl/ram_access_seq_pkg.sv
// Shared definitions for the RAM access sequencer: state encoding,
// phase counter width and default strobe timing.
package ram_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        PULSE = 2'd2,
        HOLD  = 2'd3
    } seq_state_e;

    localparam int CNT_W         = 8;
    localparam int DEF_ADDR_W    = 4;
    localparam int DEF_DATA_W    = 4;
    localparam int DEF_SETUP_CYC = 1;
    localparam int DEF_PULSE_CYC = 4;
    localparam int DEF_HOLD_CYC  = 4;

endpackage

// File: rtl/ram_access_seq_if.sv
// Request/response bus between a synchronous requester and the sequencer.
// master = requester side, slave = sequencer side.
interface ram_access_seq_if
    import ram_seq_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) ();
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              busy;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, busy
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, busy
    );
endinterface

// File: rtl/ram_access_seq_phase_timer.sv
// Loadable down-counter timing each sequencer phase; parks at zero.
module phase_timer
    import ram_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             zero_o
);
    logic [CNT_W-1:0] cnt_q;

    // Load a new phase length or count down towards zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/ram_access_seq.sv
// Turns one valid/ready request into the asynchronous RAM strobe sequence
// (setup -> WR/RD pulse -> hold) and returns a one-cycle response.
module ram_access_seq
    import ram_seq_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int SETUP_CYC = DEF_SETUP_CYC,
    parameter int PULSE_CYC = DEF_PULSE_CYC,
    parameter int HOLD_CYC  = DEF_HOLD_CYC
) (
    input  logic              clk,
    input  logic              rst_n,
    ram_access_seq_if.slave   bus,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_dataIN,
    output logic              ram_WR,
    output logic              ram_RD,
    input  logic [DATA_W-1:0] ram_dataOUT
);
    // Phase lengths are loaded as N-1 so that a count of 0 marks the last cycle.
    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);

    if (SETUP_CYC < 1 || SETUP_CYC > 255 ||
        PULSE_CYC < 1 || PULSE_CYC > 255 ||
        HOLD_CYC  < 1 || HOLD_CYC  > 255) begin : g_bad_cfg
        $error("ram_access_seq: SETUP/PULSE/HOLD_CYC must each be in 1..255");
    end

    seq_state_e        state_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              wr_q;
    logic              rd_q;
    logic              ready_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rdata_q;

    logic              tmr_load_d;
    logic [CNT_W-1:0]  tmr_val_d;
    logic              tmr_zero;
    logic              accept;

    assign accept = bus.req_valid && ready_q;

    // Reload the phase timer on acceptance and at the end of each timed phase.
    always_comb begin
        tmr_load_d = 1'b0;
        tmr_val_d  = '0;
        case (state_q)
            IDLE: begin
                tmr_load_d = accept;
                tmr_val_d  = SETUP_LD;
            end
            SETUP: begin
                tmr_load_d = tmr_zero;
                tmr_val_d  = PULSE_LD;
            end
            PULSE: begin
                tmr_load_d = tmr_zero;
                tmr_val_d  = HOLD_LD;
            end
            default: begin
                tmr_load_d = 1'b0;
                tmr_val_d  = '0;
            end
        endcase
    end

    phase_timer u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load_d),
        .load_val_i (tmr_val_d),
        .zero_o     (tmr_zero)
    );

    // Sequencer FSM; strobes, ready and response are all registered so the RAM sees clean edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wr_q        <= 1'b0;
            rd_q        <= 1'b0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        we_q    <= bus.req_we;
                        addr_q  <= bus.req_addr;
                        wdata_q <= bus.req_wdata;
                        ready_q <= 1'b0;
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    if (tmr_zero) begin
                        wr_q    <= we_q;
                        rd_q    <= !we_q;
                        state_q <= PULSE;
                    end
                end
                PULSE: begin
                    if (tmr_zero) begin
                        // RD is still high on this edge, so dataOUT is valid.
                        if (!we_q) begin
                            rdata_q <= ram_dataOUT;
                        end
                        wr_q    <= 1'b0;
                        rd_q    <= 1'b0;
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (tmr_zero) begin
                        rsp_valid_q <= 1'b1;
                        ready_q     <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.busy      = (state_q != IDLE);
    assign ram_addr      = addr_q;
    assign ram_dataIN    = wdata_q;
    assign ram_WR        = wr_q;
    assign ram_RD        = rd_q;
endmodule

// File: tb/tb_ram_access_seq.sv
// Bench for ram_access_seq: default-timing instance plus a 1/1/1 instance,
// each driving its own 16x4 RAM model, with an in-order response scoreboard.
module tb_ram_access_seq;
    localparam int S  = 1;
    localparam int P  = 4;
    localparam int H  = 4;
    localparam int SF = 1;
    localparam int PF = 1;
    localparam int HF = 1;

    typedef struct packed {
        logic       we;
        logic [3:0] rdata;
        int         due;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    int wr_cycles = 0;
    int rd_cycles = 0;

    exp_t sb_q[$];
    exp_t sbf_q[$];
    logic [3:0] ref_mem   [16];
    logic [3:0] ref_mem_f [16];
    logic [3:0] last_rd   = 4'h0;
    logic [3:0] last_rd_f = 4'h0;

    // Default-timing DUT and its RAM
    ram_access_seq_if #(.ADDR_W(4), .DATA_W(4)) bus ();
    logic [3:0] ram_addr, ram_dataIN, ram_dataOUT;
    logic       ram_WR, ram_RD;
    logic [3:0] mem [16];

    ram_access_seq #(.ADDR_W(4), .DATA_W(4), .SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .ram_addr(ram_addr), .ram_dataIN(ram_dataIN), .ram_WR(ram_WR), .ram_RD(ram_RD),
        .ram_dataOUT(ram_dataOUT)
    );

    always @(posedge clk) if (ram_WR) mem[ram_addr] <= ram_dataIN;
    assign ram_dataOUT = ram_RD ? mem[ram_addr] : 4'h0;

    // Minimum-timing DUT and its RAM
    ram_access_seq_if #(.ADDR_W(4), .DATA_W(4)) bus_f ();
    logic [3:0] f_addr, f_dataIN, f_dataOUT;
    logic       f_WR, f_RD;
    logic [3:0] mem_f [16];

    ram_access_seq #(.ADDR_W(4), .DATA_W(4), .SETUP_CYC(SF), .PULSE_CYC(PF), .HOLD_CYC(HF)) u_dut_f (
        .clk(clk), .rst_n(rst_n), .bus(bus_f),
        .ram_addr(f_addr), .ram_dataIN(f_dataIN), .ram_WR(f_WR), .ram_RD(f_RD),
        .ram_dataOUT(f_dataOUT)
    );

    always @(posedge clk) if (f_WR) mem_f[f_addr] <= f_dataIN;
    assign f_dataOUT = f_RD ? mem_f[f_addr] : 4'h0;

    // Scoreboard push: on every accepting edge, predict the response from the reference memory
    initial forever begin
        exp_t e;
        @(posedge clk);
        cyc++;
        if (!rst_n) begin
            last_rd   = 4'h0;
            last_rd_f = 4'h0;
        end else begin
            if (bus.req_valid && bus.req_ready) begin
                e.we = bus.req_we;
                if (bus.req_we) begin
                    e.rdata = last_rd;
                    ref_mem[bus.req_addr] = bus.req_wdata;
                end else begin
                    e.rdata = ref_mem[bus.req_addr];
                    last_rd = e.rdata;
                end
                e.due = cyc + S + P + H;
                sb_q.push_back(e);
            end
            if (bus_f.req_valid && bus_f.req_ready) begin
                e.we = bus_f.req_we;
                if (bus_f.req_we) begin
                    e.rdata = last_rd_f;
                    ref_mem_f[bus_f.req_addr] = bus_f.req_wdata;
                end else begin
                    e.rdata = ref_mem_f[bus_f.req_addr];
                    last_rd_f = e.rdata;
                end
                e.due = cyc + SF + PF + HF;
                sbf_q.push_back(e);
            end
        end
    end

    // Scoreboard pop: compare every response against the oldest prediction
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (ram_WR) wr_cycles++;
        if (ram_RD) rd_cycles++;
        vectors++;
        if (ram_WR && ram_RD) begin
            errors++;
            $display("FAIL strobes_both_high: WR=%0b RD=%0b, required not both 1", ram_WR, ram_RD);
        end
        if (bus.rsp_valid) begin
            vectors++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected: rsp_valid=1 at edge %0d, required 0", cyc);
            end else begin
                e = sb_q.pop_front();
                if (bus.rsp_rdata !== e.rdata) begin
                    errors++;
                    $display("FAIL rsp_rdata: got %h, required %h (we=%0b)", bus.rsp_rdata, e.rdata, e.we);
                end
                vectors++;
                if (cyc != e.due) begin
                    errors++;
                    $display("FAIL rsp_latency: response after edge %0d, required edge %0d", cyc, e.due);
                end
            end
        end
        if (bus_f.rsp_valid) begin
            vectors++;
            if (sbf_q.size() == 0) begin
                errors++;
                $display("FAIL rsp_f_unexpected: rsp_valid=1 at edge %0d, required 0", cyc);
            end else begin
                e = sbf_q.pop_front();
                if (bus_f.rsp_rdata !== e.rdata) begin
                    errors++;
                    $display("FAIL rsp_f_rdata: got %h, required %h (we=%0b)", bus_f.rsp_rdata, e.rdata, e.we);
                end
                vectors++;
                if (cyc != e.due) begin
                    errors++;
                    $display("FAIL rsp_f_latency: response after edge %0d, required edge %0d", cyc, e.due);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "watchdog");
    end

    task automatic issue(input logic we, input logic [3:0] a, input logic [3:0] d);
        int w;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_wdata = d;
        w = 0;
        while (!bus.req_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        vectors++;
        if (!bus.req_ready) begin
            errors++;
            $display("FAIL issue_timeout: req_ready=0 after %0d cycles, required 1", w);
            bus.req_valid = 1'b0;
        end else begin
            @(posedge clk);
            @(negedge clk);
            bus.req_valid = 1'b0;
        end
    endtask

    task automatic issue_f(input logic we, input logic [3:0] a, input logic [3:0] d);
        int w;
        @(negedge clk);
        bus_f.req_valid = 1'b1;
        bus_f.req_we    = we;
        bus_f.req_addr  = a;
        bus_f.req_wdata = d;
        w = 0;
        while (!bus_f.req_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        vectors++;
        if (!bus_f.req_ready) begin
            errors++;
            $display("FAIL issue_f_timeout: req_ready=0 after %0d cycles, required 1", w);
            bus_f.req_valid = 1'b0;
        end else begin
            @(posedge clk);
            @(negedge clk);
            bus_f.req_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int w = 0;
        while ((bus.busy || bus_f.busy || sb_q.size() != 0 || sbf_q.size() != 0) && w < 100) begin
            @(negedge clk);
            w++;
        end
        vectors++;
        if (bus.busy || bus_f.busy || sb_q.size() != 0 || sbf_q.size() != 0) begin
            errors++;
            $display("FAIL idle_timeout: busy=%0b/%0b pending=%0d/%0d, required idle",
                     bus.busy, bus_f.busy, sb_q.size(), sbf_q.size());
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({ram_WR, ram_RD, bus.rsp_valid, bus.req_ready, bus.busy, ram_addr, ram_dataIN} !== 13'd0) begin
            errors++;
            $display("FAIL reset_outputs: WR=%0b RD=%0b rsp=%0b rdy=%0b busy=%0b addr=%h din=%h, required all 0",
                     ram_WR, ram_RD, bus.rsp_valid, bus.req_ready, bus.busy, ram_addr, ram_dataIN);
        end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.req_ready !== 1'b1 || bus_f.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: req_ready=%0b/%0b, required 1/1", bus.req_ready, bus_f.req_ready);
        end
    endtask

    task automatic test_write_timing();
        int wr_cnt = 0;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 4'd3; bus.req_wdata = 4'h8;
        vectors++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL wt_ready_idle: req_ready=%0b, required 1", bus.req_ready);
        end
        @(posedge clk);
        for (int n = 0; n <= 10; n++) begin
            @(negedge clk);
            if (n == 0) bus.req_valid = 1'b0;
            if (ram_WR) wr_cnt++;
            vectors++;
            if (ram_WR !== (n >= S && n < S + P)) begin
                errors++;
                $display("FAIL wt_wr n=%0d: WR=%0b, required %0b", n, ram_WR, (n >= S && n < S + P));
            end
            vectors++;
            if (n < S + P + H && (ram_addr !== 4'd3 || ram_dataIN !== 4'h8)) begin
                errors++;
                $display("FAIL wt_stable n=%0d: addr=%h din=%h, required 3/8", n, ram_addr, ram_dataIN);
            end
            vectors++;
            if (bus.rsp_valid !== (n == S + P + H)) begin
                errors++;
                $display("FAIL wt_rsp n=%0d: rsp_valid=%0b, required %0b", n, bus.rsp_valid, (n == S + P + H));
            end
            vectors++;
            if (bus.req_ready !== (n >= S + P + H)) begin
                errors++;
                $display("FAIL wt_ready n=%0d: req_ready=%0b, required %0b", n, bus.req_ready, (n >= S + P + H));
            end
        end
        vectors++;
        if (wr_cnt != P) begin
            errors++;
            $display("FAIL wt_wr_width: WR high %0d cycles, required %0d", wr_cnt, P);
        end
        wait_idle();
    endtask

    task automatic test_sweep();
        int wr0, rd0;
        wr0 = wr_cycles; rd0 = rd_cycles;
        for (int i = 0; i < 16; i++) issue(1'b1, 4'(i), 4'((5 + i) % 16));
        wait_idle();
        vectors++;
        if (wr_cycles - wr0 != 16 * P || rd_cycles != rd0) begin
            errors++;
            $display("FAIL sweep_write_strobes: WR cycles=%0d RD cycles=%0d, required %0d/0",
                     wr_cycles - wr0, rd_cycles - rd0, 16 * P);
        end
        wr0 = wr_cycles; rd0 = rd_cycles;
        for (int i = 0; i < 16; i++) issue(1'b0, 4'(i), 4'h0);
        wait_idle();
        vectors++;
        if (rd_cycles - rd0 != 16 * P || wr_cycles != wr0) begin
            errors++;
            $display("FAIL sweep_read_strobes: RD cycles=%0d WR cycles=%0d, required %0d/0",
                     rd_cycles - rd0, wr_cycles - wr0, 16 * P);
        end
    endtask

    task automatic test_back_to_back();
        int acc [3];
        int idx = 0;
        int t = 0;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 4'd1; bus.req_wdata = 4'h0;
        while (idx < 3 && t < 60) begin
            @(posedge clk);
            t++;
            if (bus.req_valid && bus.req_ready) begin
                acc[idx] = t;
                idx++;
            end
            @(negedge clk);
            if (idx < 3) bus.req_addr = 4'(idx + 1);
            else bus.req_valid = 1'b0;
            if (bus.busy) begin
                vectors++;
                if (bus.req_ready !== 1'b0 && !bus.rsp_valid) begin
                    errors++;
                    $display("FAIL b2b_ready_busy: req_ready=%0b while busy, required 0", bus.req_ready);
                end
            end
        end
        bus.req_valid = 1'b0;
        vectors++;
        if (idx != 3) begin
            errors++;
            $display("FAIL b2b_accepts: %0d accepted, required 3", idx);
        end else begin
            vectors++;
            if (acc[1] - acc[0] != S + P + H + 1 || acc[2] - acc[1] != S + P + H + 1) begin
                errors++;
                $display("FAIL b2b_period: %0d/%0d cycles, required %0d", acc[1] - acc[0], acc[2] - acc[1], S + P + H + 1);
            end
        end
        wait_idle();
    endtask

    task automatic test_addr_hold();
        issue(1'b1, 4'd5, 4'hA);
        bus.req_addr = 4'hC; bus.req_wdata = 4'h3;
        for (int n = 0; n < 12; n++) begin
            vectors++;
            if (ram_addr !== 4'd5 || ram_dataIN !== 4'hA) begin
                errors++;
                $display("FAIL hold_addr n=%0d: addr=%h din=%h, required 5/A", n, ram_addr, ram_dataIN);
            end
            @(negedge clk);
        end
        issue(1'b1, 4'hC, 4'h3);
        vectors++;
        if (ram_addr !== 4'hC || ram_dataIN !== 4'h3) begin
            errors++;
            $display("FAIL hold_next: addr=%h din=%h, required C/3", ram_addr, ram_dataIN);
        end
        wait_idle();
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 4'd7; bus.req_wdata = 4'h1;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        vectors++;
        if (ram_WR !== 1'b1) begin
            errors++;
            $display("FAIL rm_wr_before: WR=%0b in 2nd pulse cycle, required 1", ram_WR);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (ram_WR !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL rm_async_drop: WR=%0b busy=%0b right after reset, required 0/0", ram_WR, bus.busy);
        end
        sb_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rm_ready: req_ready=%0b after release, required 1", bus.req_ready);
        end
        issue(1'b0, 4'd10, 4'h0);
        wait_idle();
    endtask

    task automatic test_fast();
        issue_f(1'b1, 4'd2, 4'h6);
        issue_f(1'b1, 4'd9, 4'hC);
        wait_idle();
        @(negedge clk);
        bus_f.req_valid = 1'b1; bus_f.req_we = 1'b0; bus_f.req_addr = 4'd9; bus_f.req_wdata = 4'h0;
        @(posedge clk);
        for (int n = 0; n <= 3; n++) begin
            @(negedge clk);
            if (n == 0) bus_f.req_valid = 1'b0;
            vectors++;
            if (f_RD !== (n == SF) || f_WR !== 1'b0) begin
                errors++;
                $display("FAIL fast_rd n=%0d: RD=%0b WR=%0b, required %0b/0", n, f_RD, f_WR, (n == SF));
            end
            vectors++;
            if (bus_f.rsp_valid !== (n == SF + PF + HF)) begin
                errors++;
                $display("FAIL fast_rsp n=%0d: rsp_valid=%0b, required %0b", n, bus_f.rsp_valid, (n == SF + PF + HF));
            end
        end
        vectors++;
        if (bus_f.rsp_rdata !== 4'hC) begin
            errors++;
            $display("FAIL fast_rdata: got %h, required C", bus_f.rsp_rdata);
        end
        issue_f(1'b0, 4'd2, 4'h0);
        wait_idle();
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = 4'h0; bus.req_wdata = 4'h0;
        bus_f.req_valid = 1'b0; bus_f.req_we = 1'b0; bus_f.req_addr = 4'h0; bus_f.req_wdata = 4'h0;
        test_reset();
        $display("test_reset done: vectors=%0d miscompares=%0d", vectors, errors);
        test_write_timing();
        $display("test_write_timing done: vectors=%0d miscompares=%0d", vectors, errors);
        test_sweep();
        $display("test_sweep done: vectors=%0d miscompares=%0d", vectors, errors);
        test_back_to_back();
        $display("test_back_to_back done: vectors=%0d miscompares=%0d", vectors, errors);
        test_addr_hold();
        $display("test_addr_hold done: vectors=%0d miscompares=%0d", vectors, errors);
        test_reset_mid();
        $display("test_reset_mid done: vectors=%0d miscompares=%0d", vectors, errors);
        test_fast();
        $display("test_fast done: vectors=%0d miscompares=%0d", vectors, errors);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
